// File: rtl/pc_pkg.sv
// Shared types and default parameters for the URCPU fetch-stage PC sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_ILLEGAL,
    SEL_RET,
    SEL_CALL,
    SEL_JMP,
    SEL_BR,
    SEL_INC
  } pc_sel_t;

  localparam int          PC_WIDTH_DEF    = 20;
  localparam int unsigned PC_STEP_DEF     = 1;
  localparam int unsigned PC_RESET_DEF    = 0;
  localparam int unsigned PC_RS_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_rstack.sv
// Circular return-address LIFO; a push while full overwrites the oldest entry.
module pc_rstack #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    top_idx;

  // ptr_q is the next write slot; the top sits one below it, modulo DEPTH.
  assign top_idx = ptr_q - ONE_A;
  assign top_o   = mem_q[top_idx];
  assign count_o = count_q;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i) begin
      ptr_d = ptr_q + ONE_A;
      if (count_q != DEPTH_C) begin
        count_d = count_q + CW'(1);
      end
    end else if (pop_i && (count_q != '0)) begin
      ptr_d   = ptr_q - ONE_A;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Contents need no reset: pointer and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer for the URCPU fetch stage.
// Optional hardware return-address stack enabled by defining PC_RSTACK_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned STEP     = PC_STEP_DEF,
  parameter int unsigned RESET_PC = PC_RESET_DEF,
  parameter int unsigned RS_DEPTH = PC_RS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             jmp_i,
  input  logic [WIDTH-1:0] jmp_addr_i,
  input  logic             br_i,
  input  logic [WIDTH-1:0] br_off_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_seq_o,
  output logic             wrap_o,
  output logic             rs_err_o,
  output logic             rs_empty_o,
  output logic             rs_full_o
);

  // sel          | meaning
  // SEL_HOLD     | stalled, nothing changes
  // SEL_ILLEGAL  | call and ret together, pc holds, error pulse
  // SEL_RET      | pop top into pc (increment + error if empty)
  // SEL_CALL     | push pc_seq, go to jmp_addr_i
  // SEL_JMP      | absolute jump
  // SEL_BR       | pc + signed offset
  // SEL_INC      | pc + STEP

  if (RS_DEPTH < 2 || (RS_DEPTH & (RS_DEPTH - 1)) != 0) begin : g_bad_rs_depth
    $error("pc_sequencer: RS_DEPTH must be a power of two >= 2");
  end

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);

  pc_sel_t          sel;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic             rs_err_q, rs_err_d;
  logic [WIDTH:0]   inc_sum, br_sum;
  logic             br_wrap;
  logic [WIDTH-1:0] rs_top;
  logic             rs_empty, rs_full;

  assign inc_sum = {1'b0, pc_q} + {1'b0, STEP_W};
  assign br_sum  = {1'b0, pc_q} + {1'b0, br_off_i};
  // Negative offset: a missing carry means the result went below zero.
  assign br_wrap = br_off_i[WIDTH-1] ? ~br_sum[WIDTH] : br_sum[WIDTH];

`ifdef PC_RSTACK_EN
  localparam int RS_CW = $clog2(RS_DEPTH) + 1;

  logic [RS_CW-1:0] rs_count;
  logic             rs_push, rs_pop;

  assign rs_push  = (sel == SEL_CALL);
  assign rs_pop   = (sel == SEL_RET) && !rs_empty;
  assign rs_empty = (rs_count == '0);
  assign rs_full  = (rs_count == RS_CW'(RS_DEPTH));

  pc_rstack #(
    .WIDTH (WIDTH),
    .DEPTH (RS_DEPTH)
  ) u_rstack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rs_push),
    .pop_i   (rs_pop),
    .data_i  (pc_seq_o),
    .top_o   (rs_top),
    .count_o (rs_count)
  );

  always_comb begin
    sel = SEL_HOLD;
    if (adv_i) begin
      if (ret_i && call_i) sel = SEL_ILLEGAL;
      else if (ret_i)      sel = SEL_RET;
      else if (call_i)     sel = SEL_CALL;
      else if (jmp_i)      sel = SEL_JMP;
      else if (br_i)       sel = SEL_BR;
      else                 sel = SEL_INC;
    end
  end
`else
  assign rs_top   = '0;
  assign rs_empty = 1'b1;
  assign rs_full  = 1'b0;

  // Without a stack, ret keeps its priority slot but just increments,
  // and call degrades to a plain jump.
  always_comb begin
    sel = SEL_HOLD;
    if (adv_i) begin
      if (ret_i)                sel = SEL_INC;
      else if (call_i || jmp_i) sel = SEL_JMP;
      else if (br_i)            sel = SEL_BR;
      else                      sel = SEL_INC;
    end
  end
`endif

  always_comb begin
    pc_d     = pc_q;
    wrap_d   = 1'b0;
    rs_err_d = 1'b0;
    unique case (sel)
      SEL_HOLD: ;
      SEL_ILLEGAL: rs_err_d = 1'b1;
      SEL_RET: begin
        if (rs_empty) begin
          pc_d     = inc_sum[WIDTH-1:0];
          wrap_d   = inc_sum[WIDTH];
          rs_err_d = 1'b1;
        end else begin
          pc_d = rs_top;
        end
      end
      SEL_CALL: begin
        pc_d     = jmp_addr_i;
        rs_err_d = rs_full;
      end
      SEL_JMP: pc_d = jmp_addr_i;
      SEL_BR: begin
        pc_d   = br_sum[WIDTH-1:0];
        wrap_d = br_wrap;
      end
      SEL_INC: begin
        pc_d   = inc_sum[WIDTH-1:0];
        wrap_d = inc_sum[WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_W;
      wrap_q   <= 1'b0;
      rs_err_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      wrap_q   <= wrap_d;
      rs_err_q <= rs_err_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_seq_o   = inc_sum[WIDTH-1:0];
  assign wrap_o     = wrap_q;
  assign rs_err_o   = rs_err_q;
  assign rs_empty_o = rs_empty;
  assign rs_full_o  = rs_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// stimulus checked every cycle against a queue-based reference model.
module tb_pc_sequencer;

  localparam longint MOD   = 64'h100000;
  localparam longint STEPL = 1;
  localparam longint RSTPC = 0;
  localparam int     DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adv_i = 1'b0, jmp_i = 1'b0, br_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
  logic [19:0] jmp_addr_i = '0, br_off_i = '0;
  logic [19:0] pc_o, pc_seq_o;
  logic        wrap_o, rs_err_o, rs_empty_o, rs_full_o;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (adv_i),
    .jmp_i      (jmp_i),
    .jmp_addr_i (jmp_addr_i),
    .br_i       (br_i),
    .br_off_i   (br_off_i),
    .call_i     (call_i),
    .ret_i      (ret_i),
    .pc_o       (pc_o),
    .pc_seq_o   (pc_seq_o),
    .wrap_o     (wrap_o),
    .rs_err_o   (rs_err_o),
    .rs_empty_o (rs_empty_o),
    .rs_full_o  (rs_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: PC as a plain integer, stack as a queue (newest at back).
  longint m_pc;
  bit     m_wrap, m_err, m_valid = 1'b0;
  longint stk[$];

  function automatic bit m_empty();
`ifdef PC_RSTACK_EN
    return stk.size() == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_full();
`ifdef PC_RSTACK_EN
    return stk.size() == DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_inc();
    longint s;
    s = m_pc + STEPL;
    m_wrap = (s >= MOD);
    m_pc = s % MOD;
  endtask

  task automatic m_branch(input longint off);
    longint off_s, r;
    off_s = (off >= MOD / 2) ? off - MOD : off;
    r = m_pc + off_s;
    m_wrap = (r < 0) || (r >= MOD);
    m_pc = (r < 0) ? r + MOD : r % MOD;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = RSTPC; m_wrap = 0; m_err = 0; stk.delete(); m_valid = 1;
    end else begin
      m_wrap = 0; m_err = 0;
      if (adv_i) begin
`ifdef PC_RSTACK_EN
        if (ret_i && call_i) m_err = 1;
        else if (ret_i) begin
          if (stk.size() == 0) begin m_inc(); m_err = 1; end
          else m_pc = stk.pop_back();
        end else if (call_i) begin
          if (stk.size() == DEPTH) begin void'(stk.pop_front()); m_err = 1; end
          stk.push_back((m_pc + STEPL) % MOD);
          m_pc = jmp_addr_i;
        end
`else
        if (ret_i) m_inc();
        else if (call_i) m_pc = jmp_addr_i;
`endif
        else if (jmp_i) m_pc = jmp_addr_i;
        else if (br_i)  m_branch(longint'(br_off_i));
        else            m_inc();
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc_o",       pc_o,       m_pc);
      chk("pc_seq_o",   pc_seq_o,   (m_pc + STEPL) % MOD);
      chk("wrap_o",     wrap_o,     m_wrap);
      chk("rs_err_o",   rs_err_o,   m_err);
      chk("rs_empty_o", rs_empty_o, m_empty());
      chk("rs_full_o",  rs_full_o,  m_full());
    end
  end

  task automatic cyc(input bit a, input bit j, input logic [19:0] ja,
                     input bit b, input logic [19:0] bo, input bit c, input bit r);
    adv_i = a; jmp_i = j; jmp_addr_i = ja; br_i = b; br_off_i = bo; call_i = c; ret_i = r;
    @(negedge clk);
  endtask

  task automatic jmp(input logic [19:0] a);
    cyc(1, 1, a, 0, '0, 0, 0);
  endtask

  logic [19:0] ret_exp [4];

  initial begin
    rst_n = 0;
    cyc(1, 0, '0, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, '0, 0, 0);
    chk("reset_pc", pc_o, 0);
    chk("reset_wrap", wrap_o, 0);
    chk("reset_empty", rs_empty_o, 1);
    chk("reset_full", rs_full_o, 0);
    rst_n = 1;

    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, '0, 0, '0, 0, 0);
      chk("inc_seq_pc", pc_o, i);
      chk("inc_seq_wrap", wrap_o, 0);
    end

    jmp(20'hFFFFF);
    chk("jmp_top", pc_o, 20'hFFFFF);
    cyc(1, 0, '0, 0, '0, 0, 0);
    chk("inc_wrap_pc", pc_o, 0);
    chk("inc_wrap_flag", wrap_o, 1);
    cyc(1, 0, '0, 1, 20'hFFFFF, 0, 0);
    chk("br_neg_pc", pc_o, 20'hFFFFF);
    chk("br_neg_wrap", wrap_o, 1);
    cyc(1, 0, '0, 1, 20'h00001, 0, 0);
    chk("br_pos_wrap_pc", pc_o, 0);
    chk("br_pos_wrap_flag", wrap_o, 1);

    jmp(20'h00100);
    cyc(1, 1, 20'h04000, 1, 20'h00010, 0, 0);
    chk("jmp_beats_br", pc_o, 20'h04000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 20'h12345, 1, 20'h5, 1, 0);
      chk("stall_pc", pc_o, 20'h04000);
      chk("stall_wrap", wrap_o, 0);
    end

    jmp(20'h00010);
    cyc(1, 0, 20'h08000, 0, '0, 1, 0);
    chk("call_pc", pc_o, 20'h08000);
    cyc(1, 0, '0, 0, '0, 0, 1);
`ifdef PC_RSTACK_EN
    chk("ret_pc", pc_o, 20'h00011);
`else
    chk("ret_pc", pc_o, 20'h08001);
`endif
    chk("ret_empty", rs_empty_o, 1);

`ifdef PC_RSTACK_EN
    jmp(20'h00200);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 20'((i + 1) * 'h1000), 0, '0, 1, 0);
      chk("call_fill_pc", pc_o, (i + 1) * 'h1000);
      chk("call_fill_full", rs_full_o, (i >= 3) ? 1 : 0);
      chk("call_fill_err", rs_err_o, (i == 4) ? 1 : 0);
    end
    ret_exp[0] = 20'h04001; ret_exp[1] = 20'h03001;
    ret_exp[2] = 20'h02001; ret_exp[3] = 20'h01001;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, '0, 0, '0, 0, 1);
      chk("ret_drain_pc", pc_o, ret_exp[i]);
      chk("ret_drain_err", rs_err_o, 0);
    end
    cyc(1, 0, '0, 0, '0, 0, 1);
    chk("ret_underflow_pc", pc_o, 20'h01002);
    chk("ret_underflow_err", rs_err_o, 1);
`endif

    jmp(20'h00300);
    cyc(1, 1, 20'h0ABCD, 0, '0, 1, 1);
`ifdef PC_RSTACK_EN
    chk("call_ret_pc", pc_o, 20'h00300);
    chk("call_ret_err", rs_err_o, 1);
`else
    chk("call_ret_pc", pc_o, 20'h00301);
    chk("call_ret_err", rs_err_o, 0);
`endif
    cyc(1, 0, 20'h07000, 0, '0, 1, 0);
    chk("call_as_jmp_pc", pc_o, 20'h07000);
    chk("call_as_jmp_err", rs_err_o, 0);

    cyc(1, 0, 20'h09000, 0, '0, 1, 0);
    rst_n = 0;
    cyc(1, 0, 20'h0A000, 0, '0, 1, 0);
    chk("mid_reset_pc", pc_o, 0);
    chk("mid_reset_empty", rs_empty_o, 1);
    rst_n = 1;
    cyc(1, 0, '0, 0, '0, 0, 1);
    chk("post_reset_ret_pc", pc_o, 1);

    for (int n = 0; n < 3000; n++) begin
      logic [19:0] ja, bo;
      rst_n = ($urandom_range(0, 249) != 0);
      ja = ($urandom_range(0, 3) == 0) ? (20'hFFFF0 | 20'($urandom_range(0, 15))) : 20'($urandom);
      bo = ($urandom_range(0, 1) == 0) ? 20'($urandom) : 20'($urandom_range(0, 15)) - 20'd8;
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, ja,
          $urandom_range(0, 3) == 0, bo,
          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
